// File: rtl/zjh_74hc595.sv
// zjh_74hc595: serial-in shift register with a parallel storage register.
// It tracks how full the register is, and sets a sticky overflow flag when
// bits are shifted in past a full register.
// The optional parity output Par is enabled by defining ZJH_595_PARITY_EN.
module zjh_74hc595 #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rd,
  input  logic             Ds,
  input  logic             Sh,
  input  logic             Ld,
  input  logic             Mr,
  output logic [WIDTH-1:0] Q,
  output logic             Q7s,
  output logic             Full,
  output logic             Ovf
`ifdef ZJH_595_PARITY_EN
  ,
  output logic             Par
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_FULL    = 2'd2
  } fill_t;

  fill_t            state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] st_q, st_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  // Next-state logic. Storage always samples the pre-edge shift register.
  // Mr wins over both shifting and the counter effect of Ld.
  always_comb begin
    sr_d    = sr_q;
    st_d    = st_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    state_d = state_q;

    if (Ld) begin
      st_d = sr_q;
    end

    if (Mr) begin
      sr_d  = '0;
      cnt_d = CNT_ZERO;
      ovf_d = 1'b0;
    end else begin
      if (Sh) begin
        sr_d = {sr_q[WIDTH-2:0], Ds};
      end
      if (Ld) begin
        // A bit shifted in on the load edge is the first bit of the next word.
        cnt_d = Sh ? CNT_ONE : CNT_ZERO;
        ovf_d = 1'b0;
      end else if (Sh) begin
        if (state_q == ST_FULL) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    end

    if (cnt_d == CNT_ZERO) begin
      state_d = ST_EMPTY;
    end else if (cnt_d == CNT_FULL) begin
      state_d = ST_FULL;
    end else begin
      state_d = ST_FILLING;
    end
  end

  // State registers. The asynchronous reset discards any partial fill.
  always_ff @(posedge Clk or posedge Rd) begin
    if (Rd) begin
      sr_q    <= '0;
      st_q    <= '0;
      cnt_q   <= CNT_ZERO;
      ovf_q   <= 1'b0;
      state_q <= ST_EMPTY;
    end else begin
      sr_q    <= sr_d;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
    end
  end

  assign Q    = st_q;
  assign Q7s  = sr_q[WIDTH-1];
  assign Full = (state_q == ST_FULL);
  assign Ovf  = ovf_q;

`ifdef ZJH_595_PARITY_EN
  logic par_q, par_d;

  // Parity follows the storage register, so it changes on the same edge.
  always_comb begin
    par_d = ^st_d;
  end

  // Parity register, cleared together with the storage register.
  always_ff @(posedge Clk or posedge Rd) begin
    if (Rd) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign Par = par_q;
`endif

endmodule

// File: tb/tb_zjh_74hc595.sv
// Testbench for zjh_74hc595 (WIDTH=8). It runs directed scenarios followed by
// randomized traffic, all checked against a behavioural model.
module tb_zjh_74hc595;

  logic       Clk = 1'b0;
  logic       Rd  = 1'b1;
  logic       Ds  = 1'b0;
  logic       Sh  = 1'b0;
  logic       Ld  = 1'b0;
  logic       Mr  = 1'b0;
  logic [7:0] Q;
  logic       Q7s;
  logic       Full;
  logic       Ovf;
`ifdef ZJH_595_PARITY_EN
  logic       Par;
`endif

  int checks = 0;
  int errors = 0;

  // Behavioural model: plain integers.
  int m_sr  = 0;
  int m_st  = 0;
  int m_cnt = 0;
  int m_ovf = 0;

  zjh_74hc595 #(.WIDTH(8)) dut (
    .Clk (Clk),
    .Rd  (Rd),
    .Ds  (Ds),
    .Sh  (Sh),
    .Ld  (Ld),
    .Mr  (Mr),
    .Q   (Q),
    .Q7s (Q7s),
    .Full(Full),
    .Ovf (Ovf)
`ifdef ZJH_595_PARITY_EN
    ,
    .Par (Par)
`endif
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sr = 0; m_st = 0; m_cnt = 0; m_ovf = 0;
  endtask

  task automatic model_edge(input int sh, input int ld, input int mr, input int ds);
    int old_sr;
    old_sr = m_sr;
    if (ld != 0) m_st = old_sr;
    if (mr != 0) begin
      m_sr = 0; m_cnt = 0; m_ovf = 0;
    end else begin
      if (sh != 0) m_sr = (old_sr * 2 + ds) % 256;
      if (ld != 0) begin
        m_cnt = (sh != 0) ? 1 : 0;
        m_ovf = 0;
      end else if (sh != 0) begin
        if (m_cnt == 8) m_ovf = 1;
        else m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic step(input int sh, input int ld, input int mr, input int ds);
    @(negedge Clk);
    Sh = 1'(sh); Ld = 1'(ld); Mr = 1'(mr); Ds = 1'(ds);
    @(posedge Clk);
    #1;
    model_edge(sh, ld, mr, ds);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".Q"},    32'(Q),          32'(m_st));
    chk({tag, ".Q7s"},  32'(Q7s),        32'((m_sr / 128) % 2));
    chk({tag, ".Full"}, 32'(Full),       32'(m_cnt == 8));
    chk({tag, ".Ovf"},  32'(Ovf),        32'(m_ovf));
    chk({tag, ".sr"},   32'(dut.sr_q),   32'(m_sr));
    chk({tag, ".cnt"},  32'(dut.cnt_q),  32'(m_cnt));
`ifdef ZJH_595_PARITY_EN
    chk({tag, ".Par"},  32'(Par),        32'($countones(m_st) % 2));
`endif
  endtask

  task automatic async_reset(input string tag);
    @(negedge Clk);
    Sh = 1'b0; Ld = 1'b0; Mr = 1'b0;
    #1 Rd = 1'b1;
    #1;
    chk({tag, ".Q"},    32'(Q),    32'h0);
    chk({tag, ".Full"}, 32'(Full), 32'h0);
    chk({tag, ".Q7s"},  32'(Q7s),  32'h0);
    chk({tag, ".Ovf"},  32'(Ovf),  32'h0);
    #1 Rd = 1'b0;
    model_reset();
  endtask

  initial begin
    int bits [8];
    int v;
    int r;
    bits = '{1, 0, 1, 1, 0, 0, 1, 0};

    // Reset state before any clock edge
    #3;
    chk("rst.Q",    32'(Q),    32'h0);
    chk("rst.Q7s",  32'(Q7s),  32'h0);
    chk("rst.Full", 32'(Full), 32'h0);
    chk("rst.Ovf",  32'(Ovf),  32'h0);
    @(negedge Clk);
    Rd = 1'b0;
    model_reset();

    // Basic fill of 1,0,1,1,0,0,1,0 then load
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0, bits[i]);
      if (i == 6) chk("fill.notfull7", 32'(Full), 32'h0);
      check_all("fill");
    end
    chk("fill.full8", 32'(Full), 32'h1);
    chk("fill.q7s", 32'(Q7s), 32'h1);
    step(0, 1, 0, 0);
    chk("fill.Qload", 32'(Q), 32'hB2);
    chk("fill.fullclr", 32'(Full), 32'h0);
    check_all("fill_ld");

    // Simultaneous load and shift with sr=B2
    step(1, 1, 0, 1);
    chk("ldsh.Q",   32'(Q),         32'hB2);
    chk("ldsh.sr",  32'(dut.sr_q),  32'h65);
    chk("ldsh.cnt", 32'(dut.cnt_q), 32'h1);
    check_all("ldsh");

    // Overflow after 9 shifts from empty
    step(0, 0, 1, 0);
    for (int i = 0; i < 9; i++) begin
      step(1, 0, 0, int'($urandom_range(0, 1)));
      if (i == 7) chk("ovf.notyet", 32'(Ovf), 32'h0);
      check_all("ovf");
    end
    chk("ovf.set",  32'(Ovf),         32'h1);
    chk("ovf.full", 32'(Full),        32'h1);
    chk("ovf.cnt",  32'(dut.cnt_q),   32'h8);
    step(0, 1, 0, 0);
    chk("ovf.clr",  32'(Ovf),         32'h0);
    check_all("ovf_ld");

    // Mr priority: sr=FF, Q=0F, then Mr with Sh
    step(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1);
    step(0, 1, 0, 0);
    chk("mr.Q0F", 32'(Q), 32'h0F);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1);
    chk("mr.srFF", 32'(dut.sr_q), 32'hFF);
    step(1, 0, 1, 1);
    chk("mr.sr",  32'(dut.sr_q),  32'h0);
    chk("mr.cnt", 32'(dut.cnt_q), 32'h0);
    chk("mr.Q",   32'(Q),         32'h0F);
    chk("mr.Q7s", 32'(Q7s),       32'h0);
    check_all("mr");

    // Mr together with Ld still loads the pre-clear contents
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1);
    step(0, 1, 1, 0);
    chk("mrld.Q", 32'(Q), 32'h07);
    check_all("mrld");

    // Asynchronous reset in the middle of a fill
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1);
    async_reset("arst");
    v = 0;
    for (int i = 0; i < 8; i++) begin
      r = int'($urandom_range(0, 1));
      v = v * 2 + r;
      step(1, 0, 0, r);
    end
    step(0, 1, 0, 0);
    chk("arst.Q", 32'(Q), 32'(v));
    check_all("arst_ld");

`ifdef ZJH_595_PARITY_EN
    // Parity of loaded words
    step(0, 0, 1, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 0, bits[i]);
    step(0, 1, 0, 0);
    chk("par.B2", 32'(Par), 32'h0);
    for (int i = 0; i < 8; i++) step(1, 0, 0, (i >= 5) ? 1 : 0);
    step(0, 1, 0, 0);
    chk("par.07q", 32'(Q), 32'h07);
    chk("par.07", 32'(Par), 32'h1);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      int sh, ld, mr, ds;
      sh = ($urandom_range(0, 3) != 0) ? 1 : 0;
      ld = ($urandom_range(0, 9) == 0) ? 1 : 0;
      mr = ($urandom_range(0, 29) == 0) ? 1 : 0;
      ds = int'($urandom_range(0, 1));
      step(sh, ld, mr, ds);
      check_all("rand");
      if (n % 97 == 50) async_reset("rand_arst");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
